serial_adder_ctrl: RTL and testbench



---
 rtl/serial_adder_ctrl.sv | 152 +++++++++++++++
 tb/tb_serial_adder_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : serial_adder_ctrl (with its shared full_adder)
// Brief    : Bit-serial adder, one full adder reused LSB-first, one bit/clock.
// Revision : 1.0 - initial release
// ============================================================================

module full_adder (
   input  logic in1,
   input  logic in2,
   input  logic cin,
   output logic sum,
   output logic cout
);
   assign sum  = in1 ^ in2 ^ cin;
   assign cout = (in1 & in2) | (cin & (in1 ^ in2));
endmodule

module serial_adder_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);
   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_PENULT = CNT_W'(WIDTH - 2);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [WIDTH-2:0] s_sh_q, s_sh_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             c_ff_q, c_ff_d;
   logic             c_msb_q, c_msb_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;

   logic             fa_sum;
   logic             fa_cout;
   logic [WIDTH-1:0] s_next;

   full_adder u_fa (
      .in1  (a_sh_q[0]),
      .in2  (b_sh_q[0]),
      .cin  (c_ff_q),
      .sum  (fa_sum),
      .cout (fa_cout)
   );

   // Partial sum only needs WIDTH-1 stored bits; the new bit completes the word.
   assign s_next = {fa_sum, s_sh_q};

   always_comb begin
      state_d = state_q;
      a_sh_d  = a_sh_q;
      b_sh_d  = b_sh_q;
      s_sh_d  = s_sh_q;
      cnt_d   = cnt_q;
      c_ff_d  = c_ff_q;
      c_msb_d = c_msb_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               a_sh_d  = op_a;
               b_sh_d  = op_b;
               c_ff_d  = cin;
               c_msb_d = 1'b0;
               cnt_d   = '0;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            a_sh_d = {1'b0, a_sh_q[WIDTH-1:1]};
            b_sh_d = {1'b0, b_sh_q[WIDTH-1:1]};
            s_sh_d = s_next[WIDTH-1:1];
            c_ff_d = fa_cout;
            // Carry out of bit WIDTH-2 is the carry into the MSB.
            if (cnt_q == CNT_PENULT) begin
               c_msb_d = fa_cout;
            end
            if (cnt_q == CNT_LAST) begin
               sum_d   = s_next;
               cout_d  = fa_cout;
               ovf_d   = c_msb_q ^ fa_cout;
               state_d = ST_DONE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         a_sh_q  <= '0;
         b_sh_q  <= '0;
         s_sh_q  <= '0;
         cnt_q   <= '0;
         c_ff_q  <= 1'b0;
         c_msb_q <= 1'b0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_sh_q  <= a_sh_d;
         b_sh_q  <= b_sh_d;
         s_sh_q  <= s_sh_d;
         cnt_q   <= cnt_d;
         c_ff_q  <= c_ff_d;
         c_msb_q <= c_msb_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end

   assign busy = (state_q == ST_RUN);
   assign done = (state_q == ST_DONE);
   assign sum  = sum_q;
   assign cout = cout_q;
   assign ovf  = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_adder_ctrl
// Brief    : Scoreboard bench for serial_adder_ctrl against an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================

module tb_serial_adder_ctrl;
   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] op_a;
   logic [W-1:0] op_b;
   logic         cin;
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         cout;
   logic         ovf;

   int           total = 0;
   int           bad = 0;
   logic [W+1:0] exp_q[$];
   logic [W+1:0] held = '0;
   logic [W+1:0] popped;
   logic         rst_smp;
   logic         mon_en = 1'b0;

   always #5 clk = ~clk;

   serial_adder_ctrl #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .op_a  (op_a),
      .op_b  (op_b),
      .cin   (cin),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout),
      .ovf   (ovf)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: plain integer addition, signed overflow from range of signed sum.
   function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic c);
      int unsigned u;
      int          sa, sb, s;
      logic        o;
      u  = int'(a) + int'(b) + int'(c);
      sa = a[W-1] ? int'(a) - (1 << W) : int'(a);
      sb = b[W-1] ? int'(b) - (1 << W) : int'(b);
      s  = sa + sb + int'(c);
      o  = (s > (1 << (W - 1)) - 1) || (s < -(1 << (W - 1)));
      return {o, u[W], u[W-1:0]};
   endfunction

   always @(posedge clk) rst_smp <= rst;

   always @(negedge clk) begin
      if (mon_en) begin
         if (rst_smp === 1'b1) begin
            check("reset_clear", {done, busy, ovf, cout, sum}, '0);
            held = '0;
         end else if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_done: got done=1 expected no pending op at %0t", $time);
            end else begin
               popped = exp_q.pop_front();
               check("result", {ovf, cout, sum}, popped);
            end
            check("busy_in_done", busy, 1'b0);
            held = {ovf, cout, sum};
         end else begin
            check("held_stable", {ovf, cout, sum}, held);
         end
      end
   end

   // Issue one addition from IDLE, scramble inputs during RUN, check timing.
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
      int lat;
      int nbusy;
      op_a  = a;
      op_b  = b;
      cin   = c;
      start = 1'b1;
      exp_q.push_back(model(a, b, c));
      @(posedge clk); #1;
      start = 1'b0;
      op_a  = W'($urandom);
      op_b  = W'($urandom);
      cin   = 1'($urandom);
      lat   = -1;
      nbusy = 0;
      for (int e = 0; e <= 4 * W && lat < 0; e++) begin
         if (e > 0) begin
            @(posedge clk); #1;
         end
         if (done === 1'b1) lat = e;
         else if (busy === 1'b1) nbusy++;
      end
      check("latency", lat, W);
      check("busy_cycles", nbusy, W);
      @(posedge clk); #1;
   endtask

   task automatic directed(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                           input logic [W-1:0] es, input logic ec, input logic eo);
      run_op(a, b, c);
      check("dir_sum", sum, es);
      check("dir_cout", cout, ec);
      check("dir_ovf", ovf, eo);
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: got no completion expected finish before 2ms");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int ndone;
      int d[$];
      logic prev_done;
      rst   = 1'b1;
      start = 1'b0;
      op_a  = '0;
      op_b  = '0;
      cin   = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_state", {done, busy, ovf, cout, sum}, '0);
      mon_en = 1'b1;
      rst    = 1'b0;
      @(posedge clk); #1;

      directed(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);
      directed(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
      directed(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
      directed(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
      directed(8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0);
      directed(8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0);

      // Operand change and extra start pulse during RUN must be ignored.
      op_a = 8'h12; op_b = 8'h34; cin = 1'b0; start = 1'b1;
      exp_q.push_back(model(8'h12, 8'h34, 1'b0));
      @(posedge clk); #1;
      start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      op_a = 8'hFF; op_b = 8'hFF; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      ndone = 0;
      for (int e = 0; e < 3 * W; e++) begin
         @(posedge clk); #1;
         if (done === 1'b1) ndone++;
      end
      check("midrun_done_count", ndone, 1);
      check("midrun_sum", sum, 8'h46);
      check("midrun_not_queued", busy, 1'b0);

      // Reset in the middle of RUN aborts without a done pulse.
      op_a = 8'h55; op_b = 8'hAA; cin = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      ndone = 0;
      for (int e = 0; e < 2 * W; e++) begin
         @(posedge clk); #1;
         if (done === 1'b1) ndone++;
      end
      check("abort_no_done", ndone, 0);
      check("abort_outputs", {busy, ovf, cout, sum}, '0);
      directed(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0);

      // Reset and start on the same edge: start is dropped.
      rst = 1'b1; start = 1'b1; op_a = 8'h11; op_b = 8'h22;
      @(posedge clk); #1;
      rst = 1'b0; start = 1'b0;
      check("rst_beats_start", busy, 1'b0);
      @(posedge clk); #1;
      check("rst_beats_start_idle", {done, busy}, 2'b00);

      // Continuous start: one result every W+2 cycles.
      op_a = 8'h3C; op_b = 8'h0F; cin = 1'b1;
      repeat (3) exp_q.push_back(model(8'h3C, 8'h0F, 1'b1));
      start = 1'b1;
      prev_done = 1'b0;
      for (int e = 0; e <= 40; e++) begin
         @(posedge clk); #1;
         if (e == 2 * (W + 2)) start = 1'b0;
         if (prev_done) check("busy_low_after_done", busy, 1'b0);
         if (done === 1'b1) begin
            d.push_back(e);
            check("busy_low_in_done", busy, 1'b0);
         end
         prev_done = (done === 1'b1);
      end
      check("held_start_count", d.size(), 3);
      if (d.size() == 3) begin
         check("held_start_first", d[0], W);
         check("held_start_period1", d[1] - d[0], W + 2);
         check("held_start_period2", d[2] - d[1], W + 2);
      end
      op_a = '0; op_b = '0; cin = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      for (int i = 0; i < 1000; i++) begin
         run_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
      end

      repeat (5) @(posedge clk);
      #1;
      check("queue_drained", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
